// File: rtl/ext_tran_pkg.sv
// rtl/ext_tran_pkg.sv - shared encodings, FSM state type and defaults for ext_tran_master
// Purpose: size encodings, FSM state type, default ack timeout and the
//          alignment check used when a transaction is accepted.
package ext_tran_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when the size is legal and the byte address is naturally aligned for it.
  function automatic logic size_ok(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: size_ok = 1'b1;
      SIZE_HALF: size_ok = ~lo[0];
      SIZE_WORD: size_ok = (lo == 2'b00);
      default:   size_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ext_tran_lane.sv
// rtl/ext_tran_lane.sv - combinational byte-lane steering for ext_tran_master
// Purpose: write-data replication, byte-enable generation and read-lane
//          extraction for a 32-bit little-endian bus.
// Ports:
//   size_i     transfer size encoding
//   addr_lo_i  byte offset within the word
//   wdata_i    right-aligned write data
//   rdata_i    raw bus read data
//   wdata_o    write data replicated across lanes
//   sel_o      byte enables (0 for the reserved size)
//   rdata_o    addressed lane(s), right-aligned and zero-extended
module ext_tran_lane
  import ext_tran_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  sel_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;

  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    rshift  = rdata_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rshift[7:0]};
      end
      SIZE_HALF: begin
        sel_o   = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, rshift[15:0]};
      end
      SIZE_WORD: begin
        sel_o   = 4'b1111;
        rdata_o = rdata_i;
      end
      default: begin
        sel_o   = 4'b0000;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/ext_tran_master.sv
// rtl/ext_tran_master.sv - single-transaction Wishbone classic master with sticky result flags
// Purpose: accepts one byte/half/word transaction, runs it as a Wishbone
//          classic cycle and reports completion, error and read data.
// Ports:
//   clk_i, reset_i                     clock, async active-low reset
//   tran_start_i/write_i/clear_i       start pulse, direction, flag clear
//   tran_size_i, tran_addr_i           size encoding, byte address
//   tran_data_i / tran_data_o          write data in / read data out
//   tran_ready_o, tran_err_o, busy_o   sticky done, sticky error, in flight
//   wb_cyc_o, wb_stb_o, wb_we_o        bus controls
//   wb_adr_o, wb_dat_o, wb_sel_o       word address, steered data, byte enables
//   wb_dat_i, wb_ack_i, wb_err_i       slave read data and termination
module ext_tran_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = ext_tran_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  tran_start_i,
  input  logic                  tran_write_i,
  input  logic                  tran_clear_i,
  input  logic [1:0]            tran_size_i,
  input  logic [ADDR_WIDTH-1:0] tran_addr_i,
  input  logic [31:0]           tran_data_i,
  output logic [31:0]           tran_data_o,
  output logic                  tran_ready_o,
  output logic                  tran_err_o,
  output logic                  busy_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);
  import ext_tran_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Last counted BUS cycle: the counter starts at 0, so this edge is the Nth.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q, lo_q;
  logic          req_ok, accept, term, bus_err, bus_ack, bus_tmo;
  logic [1:0]    lane_size, lane_lo;
  logic [31:0]   lane_wdat, lane_rdat;
  logic [3:0]    lane_sel;

  // Outside BUS the lane logic prepares the incoming request; inside BUS it
  // decodes the read data for the latched one.
  assign lane_size = (state_q == ST_BUS) ? size_q : tran_size_i;
  assign lane_lo   = (state_q == ST_BUS) ? lo_q   : tran_addr_i[1:0];

  ext_tran_lane u_lane (
    .size_i    (lane_size),
    .addr_lo_i (lane_lo),
    .wdata_i   (tran_data_i),
    .rdata_i   (wb_dat_i),
    .wdata_o   (lane_wdat),
    .sel_o     (lane_sel),
    .rdata_o   (lane_rdat)
  );

  assign req_ok  = size_ok(tran_size_i, tran_addr_i[1:0]);
  assign busy_o  = (state_q == ST_BUS);
  // err wins over a simultaneous ack; timeout only when nothing terminated.
  assign bus_err = busy_o && wb_err_i;
  assign bus_ack = busy_o && wb_ack_i && !wb_err_i;
  assign bus_tmo = busy_o && !wb_ack_i && !wb_err_i && (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    term    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tran_start_i) begin
          accept  = 1'b1;
          state_d = req_ok ? ST_BUS : ST_DONE;
        end
      end
      ST_BUS: begin
        if (bus_err || bus_ack || bus_tmo) begin
          term    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (tran_start_i) begin
          accept  = 1'b1;
          state_d = req_ok ? ST_BUS : ST_DONE;
        end else if (tran_clear_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q        <= '0;
      size_q       <= 2'b00;
      lo_q         <= 2'b00;
      tran_data_o  <= 32'h0;
      tran_ready_o <= 1'b0;
      tran_err_o   <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= 32'h0;
      wb_sel_o     <= 4'b0000;
    end else if (accept) begin
      // A rejected request lands in DONE already flagged as failed.
      tran_ready_o <= !req_ok;
      tran_err_o   <= !req_ok;
      if (req_ok) begin
        cnt_q    <= '0;
        size_q   <= tran_size_i;
        lo_q     <= tran_addr_i[1:0];
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= tran_write_i;
        wb_adr_o <= {tran_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wb_dat_o <= lane_wdat;
        wb_sel_o <= lane_sel;
      end
    end else if (term) begin
      tran_ready_o <= 1'b1;
      tran_err_o   <= bus_err || bus_tmo;
      if (bus_ack && !wb_we_o) tran_data_o <= lane_rdat;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= 32'h0;
      wb_sel_o <= 4'b0000;
    end else if (state_q == ST_BUS) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == ST_DONE && tran_clear_i) begin
      tran_ready_o <= 1'b0;
      tran_err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_tran_master.sv
// tb/tb_ext_tran_master.sv - table-driven self-checking bench for ext_tran_master
module tb_ext_tran_master;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        tran_start_i = 1'b0, tran_write_i = 1'b0, tran_clear_i = 1'b0;
  logic [1:0]  tran_size_i = 2'b00;
  logic [31:0] tran_addr_i = 32'h0, tran_data_i = 32'h0, tran_data_o;
  logic        tran_ready_o, tran_err_o, busy_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'hFFFF_FFFF;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  ext_tran_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .tran_start_i(tran_start_i), .tran_write_i(tran_write_i), .tran_clear_i(tran_clear_i),
    .tran_size_i(tran_size_i), .tran_addr_i(tran_addr_i), .tran_data_i(tran_data_i),
    .tran_data_o(tran_data_o), .tran_ready_o(tran_ready_o), .tran_err_o(tran_err_o),
    .busy_o(busy_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    int          wait_n;
    logic        ack, err, bus;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat, e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n,
                              input logic ack, input logic err, input logic bus, input logic [3:0] e_sel,
                              input logic [31:0] e_adr, input logic [31:0] e_dat,
                              input logic [31:0] e_rd, input logic e_err);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.wait_n = wait_n; v.ack = ack; v.err = err; v.bus = bus; v.e_sel = e_sel;
    v.e_adr = e_adr; v.e_dat = e_dat; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic do_clear(input string nm);
    tran_clear_i = 1'b1;
    step();
    tran_clear_i = 1'b0;
    chk1({nm, "_clr_ready"}, tran_ready_o, 1'b0);
    chk1({nm, "_clr_err"}, tran_err_o, 1'b0);
    chk1({nm, "_clr_busy"}, busy_o, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    tran_write_i = v.wr; tran_size_i = v.size; tran_addr_i = v.addr; tran_data_i = v.wdata;
    tran_start_i = 1'b1;
    step();
    tran_start_i = 1'b0;
    if (v.bus) begin
      chk1({nm, "_cyc"}, wb_cyc_o, 1'b1);
      chk1({nm, "_stb"}, wb_stb_o, 1'b1);
      chk1({nm, "_busy"}, busy_o, 1'b1);
      chk1({nm, "_we"}, wb_we_o, v.wr);
      chk1({nm, "_ready_drop"}, tran_ready_o, 1'b0);
      chk32({nm, "_sel"}, {28'h0, wb_sel_o}, {28'h0, v.e_sel});
      chk32({nm, "_adr"}, wb_adr_o, v.e_adr);
      chk32({nm, "_dat"}, wb_dat_o, v.e_dat);
      for (int i = 0; i < v.wait_n; i++) begin
        step();
        chk1({nm, "_cyc_wait"}, wb_cyc_o, 1'b1);
      end
      wb_ack_i = v.ack; wb_err_i = v.err; wb_dat_i = v.rdata;
      step();
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
      chk1({nm, "_cyc_end"}, wb_cyc_o, 1'b0);
      chk1({nm, "_busy_end"}, busy_o, 1'b0);
    end else begin
      chk1({nm, "_nocyc"}, wb_cyc_o, 1'b0);
      chk1({nm, "_nobusy"}, busy_o, 1'b0);
      step();
      chk1({nm, "_nocyc2"}, wb_cyc_o, 1'b0);
    end
    chk1({nm, "_ready"}, tran_ready_o, 1'b1);
    chk1({nm, "_err"}, tran_err_o, v.e_err);
    chk32({nm, "_rdata"}, tran_data_o, v.e_rd);
  endtask

  initial begin
    int n;
    //             wr    size   addr          wdata         rdata         wt ack err bus sel      adr           dat           rd            err
    vecs[0]  = mk(1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 1, 0, 1, 4'b1111, 32'h100, 32'hDEAD_BEEF, 32'h0,         0);
    vecs[1]  = mk(1'b0, 2'b00, 32'h0000_0103, 32'h0,        32'hAABB_CCDD, 0, 1, 0, 1, 4'b1000, 32'h100, 32'h0,         32'h0000_00AA, 0);
    vecs[2]  = mk(1'b0, 2'b01, 32'h0000_0102, 32'h0,        32'hAABB_CCDD, 1, 1, 0, 1, 4'b1100, 32'h100, 32'h0,         32'h0000_AABB, 0);
    vecs[3]  = mk(1'b1, 2'b01, 32'h0000_0002, 32'h1234_5678, 32'h0,        0, 1, 0, 1, 4'b1100, 32'h000, 32'h5678_5678, 32'h0000_AABB, 0);
    vecs[4]  = mk(1'b1, 2'b00, 32'h0000_0201, 32'h0000_00A5, 32'h0,        2, 1, 0, 1, 4'b0010, 32'h200, 32'hA5A5_A5A5, 32'h0000_AABB, 0);
    vecs[5]  = mk(1'b0, 2'b00, 32'h0000_0101, 32'h0,        32'h1122_3344, 0, 1, 0, 1, 4'b0010, 32'h100, 32'h0,         32'h0000_0033, 0);
    vecs[6]  = mk(1'b0, 2'b10, 32'h0000_0004, 32'h0,        32'h1234_5678, 1, 1, 0, 1, 4'b1111, 32'h004, 32'h0,         32'h1234_5678, 0);
    vecs[7]  = mk(1'b0, 2'b01, 32'h0000_0106, 32'h0,        32'hCAFE_F00D, 0, 1, 0, 1, 4'b1100, 32'h104, 32'h0,         32'h0000_CAFE, 0);
    vecs[8]  = mk(1'b1, 2'b01, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,         32'h0000_CAFE, 1);
    vecs[9]  = mk(1'b0, 2'b11, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,         32'h0000_CAFE, 1);
    vecs[10] = mk(1'b1, 2'b10, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,         32'h0000_CAFE, 1);
    vecs[11] = mk(1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'h9999_9999, 1, 0, 1, 1, 4'b0001, 32'h000, 32'h0,         32'h0000_CAFE, 1);
    vecs[12] = mk(1'b0, 2'b10, 32'h0000_0008, 32'h0,        32'h5555_5555, 0, 1, 1, 1, 4'b1111, 32'h008, 32'h0,         32'h0000_CAFE, 1);
    vecs[13] = mk(1'b0, 2'b00, 32'h0000_0002, 32'h0,        32'h0077_0000, 0, 1, 0, 1, 4'b0100, 32'h000, 32'h0,         32'h0000_0077, 0);

    // reset state, checked before any clock edge
    #2;
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_we", wb_we_o, 1'b0);
    chk1("rst_ready", tran_ready_o, 1'b0);
    chk1("rst_err", tran_err_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk32("rst_rdata", tran_data_o, 32'h0);
    chk32("rst_adr", wb_adr_o, 32'h0);
    chk32("rst_dat", wb_dat_o, 32'h0);
    chk32("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    step();
    step();
    reset_i = 1'b1;
    step();

    for (int k = 0; k < 14; k++) begin
      run_vec(vecs[k], $sformatf("v%0d", k));
      do_clear($sformatf("v%0d", k));
    end

    // timeout with a start and a clear injected mid-BUS
    tran_write_i = 1'b0; tran_size_i = 2'b10; tran_addr_i = 32'h0; tran_start_i = 1'b1;
    step();
    tran_start_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && wb_cyc_o; k++) begin
      n++;
      if (n == 3) begin
        tran_start_i = 1'b1; tran_write_i = 1'b1; tran_addr_i = 32'h40;
      end
      if (n == 5) tran_clear_i = 1'b1;
      step();
      tran_start_i = 1'b0;
      tran_clear_i = 1'b0;
    end
    chk32("tmo_bus_cycles", n, 8);
    chk1("tmo_ready", tran_ready_o, 1'b1);
    chk1("tmo_err", tran_err_o, 1'b1);
    chk1("tmo_stb", wb_stb_o, 1'b0);
    chk32("tmo_rdata", tran_data_o, 32'h0000_0077);
    step();
    chk1("tmo_noqueue_cyc", wb_cyc_o, 1'b0);
    chk1("tmo_noqueue_busy", busy_o, 1'b0);
    chk1("tmo_hold_ready", tran_ready_o, 1'b1);
    do_clear("tmo");

    // reset two cycles into BUS
    tran_write_i = 1'b0; tran_size_i = 2'b10; tran_addr_i = 32'h8; tran_start_i = 1'b1;
    step();
    tran_start_i = 1'b0;
    step();
    chk1("rstbus_cyc_before", wb_cyc_o, 1'b1);
    reset_i = 1'b0;
    #1;
    chk1("rstbus_cyc", wb_cyc_o, 1'b0);
    chk1("rstbus_stb", wb_stb_o, 1'b0);
    chk1("rstbus_busy", busy_o, 1'b0);
    step();
    step();
    reset_i = 1'b1;
    step();
    chk1("rstbus_idle_busy", busy_o, 1'b0);
    chk1("rstbus_idle_cyc", wb_cyc_o, 1'b0);
    run_vec(mk(1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h1234_5678, 1, 1, 0, 1, 4'b1111,
               32'h010, 32'h0, 32'h1234_5678, 0), "post_rst");

    // start and clear together in DONE: start wins
    tran_clear_i = 1'b1;
    tran_write_i = 1'b0; tran_size_i = 2'b10; tran_addr_i = 32'h0; tran_start_i = 1'b1;
    step();
    tran_clear_i = 1'b0; tran_start_i = 1'b0;
    chk1("dc_ready_drop", tran_ready_o, 1'b0);
    chk1("dc_cyc", wb_cyc_o, 1'b1);
    chk1("dc_busy", busy_o, 1'b1);
    chk32("dc_adr", wb_adr_o, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
    chk1("dc_ready", tran_ready_o, 1'b1);
    chk1("dc_err", tran_err_o, 1'b0);
    chk32("dc_rdata", tran_data_o, 32'h0BAD_F00D);
    do_clear("dc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_tran_master.md
EXT_TRAN_MASTER -- requirements
Module: ext_tran_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, transaction address width; TIMEOUT_CYCLES, default 255, maximum wait for ack before error.
REQ-002 Ports SHALL be:
- clk_i  in  1  single system clock.
- reset_i  in  1  asynchronous, active-low reset.
- tran_start_i  in  1  one-cycle start pulse.
- tran_write_i  in  1  1 = write, 0 = read.
- tran_clear_i  in  1  clears the result flags.
- tran_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- tran_addr_i  in  ADDR_WIDTH  byte address.
- tran_data_i  in  32  write data, right-aligned.
- tran_data_o  out  32  read data, right-aligned, zero-extended.
- tran_ready_o  out  1  sticky completion flag.
- tran_err_o  out  1  sticky error flag.
- busy_o  out  1  transaction in flight.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
- wb_adr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- wb_dat_o  out  32  lane-steered write data.
- wb_sel_o  out  4  byte enables.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1 each  slave termination.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUS, DONE.
REQ-004 IDLE + tran_start_i: the block SHALL latch addr, data, size and write, then go to BUS on the next edge. tran_ready_o and tran_err_o SHALL drop in that same edge.
REQ-005 A start with size=11, or with a misaligned address, SHALL skip BUS, go to DONE and set tran_err_o with no bus cycle. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
REQ-006 In BUS, wb_cyc_o and wb_stb_o SHALL be high, registered, from the first BUS cycle until the termination edge.
REQ-007 Byte enables SHALL be: byte → wb_sel_o = 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
REQ-008 Write lane steering: wb_dat_o SHALL equal tran_data_i replicated across lanes (byte ×4, half ×2, word as is).
REQ-009 wb_ack_i in BUS SHALL go to DONE and set tran_ready_o. On a read, the addressed lane(s) SHALL be captured, shifted right by 8·addr[1:0] and zero-extended into tran_data_o.
REQ-010 wb_err_i in BUS SHALL go to DONE and set both tran_ready_o and tran_err_o. tran_data_o SHALL stay unchanged.
REQ-011 If wb_ack_i and wb_err_i are high together, err SHALL win.
REQ-012 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle. When it reaches TIMEOUT_CYCLES with no termination, the block SHALL drop cyc/stb, go to DONE and set tran_ready_o and tran_err_o.
REQ-013 tran_ready_o and tran_err_o SHALL hold in DONE until tran_clear_i, or until a new start is accepted.
REQ-014 tran_start_i while BUS SHALL be ignored, with no queueing.
REQ-015 tran_clear_i while BUS SHALL be ignored.
REQ-016 In DONE, tran_clear_i SHALL clear ready and err and return to IDLE.
REQ-017 In DONE, tran_start_i SHALL be accepted as in REQ-004. If start and clear coincide, start SHALL win.
REQ-018 busy_o SHALL be 1 only in BUS.
REQ-019 Minimum latency SHALL be 2 edges from start to tran_ready_o, with zero-wait ack.

Reset
REQ-020 reset_i low SHALL asynchronously force: state IDLE; every output 0, including tran_data_o, all wb_* outputs and the timeout counter.
REQ-021 Reset during BUS SHALL drop wb_cyc_o and wb_stb_o immediately, without waiting for a clock. On release the block SHALL be in IDLE with no pending transaction.

Structure
REQ-022 Package ext_tran_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state type and the default TIMEOUT_CYCLES.
REQ-023 Lane steering SHALL be one combinational sub-module, ext_tran_lane: write replication, sel generation, read extraction.
REQ-024 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-025 Word write: addr 0x100, data 0xDEADBEEF, ack after 3 cycles → wb_sel_o=1111, wb_dat_o=0xDEADBEEF, ready=1 and err=0 after the ack edge.
REQ-026 Byte read: addr 0x103, slave returns 0xAABBCCDD → wb_sel_o=1000, wb_adr_o=0x100, tran_data_o=0x000000AA.
REQ-027 Half write, addr 0x101 → no wb_cyc_o, ready=1 and err=1 two edges after start. Then clear → both 0, state IDLE.
REQ-028 Read with no ack, TIMEOUT_CYCLES=8 → cyc drops after 8 BUS cycles, ready=1, err=1. A start pulse injected mid-BUS has no effect.
REQ-029 Reset asserted 2 cycles into BUS → wb_cyc_o=0 before the next edge. After release, a word read of 0x12345678 completes normally.
REQ-030 In DONE, clear and start together, size=10, addr 0x0 → ready drops, a new bus cycle starts, and it completes with ready=1.
